// File: rtl/regfile_pkg.sv
// Shared constants and FSM encodings for the 32x32 register file.
// Optional parity storage is enabled by defining REGFILE_PARITY_EN.
package regfile_pkg;
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: priority mux (reset/clear/r0, bypass, storage).
// With REGFILE_PARITY_EN it also flags a parity mismatch on storage reads.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_store_data,
`ifdef REGFILE_PARITY_EN
  input  logic              i_store_par,
  output logic              o_par_bad,
`endif
  output logic [DATA_W-1:0] o_rdata
);

  logic w_zero;
  logic w_bypass;
  logic w_store;

  assign w_zero   = (i_rst == RST_ENABLE) || !i_run || (i_raddr == ADDR_W'(NOP_REG_ADDR));
  assign w_bypass = !w_zero && (i_re == READ_ENABLE) && (i_we == WRITE_ENABLE) && (i_waddr == i_raddr);
  assign w_store  = !w_zero && !w_bypass && (i_re == READ_ENABLE);

  always_comb begin
    o_rdata = DATA_W'(ZERO_WORD);
    if (w_bypass)
      o_rdata = i_wdata;
    else if (w_store)
      o_rdata = i_store_data;
  end

`ifdef REGFILE_PARITY_EN
  // Only values actually fetched from storage are checked.
  assign o_par_bad = w_store && ((^i_store_data) != i_store_par);
`endif

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write bypass, one write port,
// post-reset clear sweep. Define REGFILE_PARITY_EN for per-register parity and par_err_o.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready_o,
  output logic              par_err_o
);

  rf_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic              r_ready, w_ready_nxt;

  // r0 is hardwired to zero, so storage starts at index 1.
  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] w_st1, w_st2;
  logic              w_run;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= ADDR_W'(1);
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_ready_nxt   = r_ready;
    case (r_state)
      RF_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        if (r_clr_ptr == ADDR_W'(NUM_REGS - 1)) begin
          w_state_nxt = RF_RUN;
          w_ready_nxt = 1'b1;
        end
      end
      RF_RUN: begin
        w_state_nxt = RF_RUN;
      end
      default: begin
        w_state_nxt = RF_CLEAR;
      end
    endcase
  end

  assign w_run   = (r_state == RF_RUN);
  assign ready_o = r_ready;

  // Reset cycles never write; the sweep owns the array until RUN.
  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      if (r_state == RF_CLEAR)
        r_regs[r_clr_ptr] <= '0;
      else if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR))
        r_regs[waddr] <= wdata;
    end
  end

  assign w_st1 = (raddr1 == ADDR_W'(NOP_REG_ADDR)) ? '0 : r_regs[raddr1];
  assign w_st2 = (raddr2 == ADDR_W'(NOP_REG_ADDR)) ? '0 : r_regs[raddr2];

`ifdef REGFILE_PARITY_EN
  logic r_par [1:NUM_REGS-1];
  logic w_sp1, w_sp2;
  logic w_bad1, w_bad2;
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      if (r_state == RF_CLEAR)
        r_par[r_clr_ptr] <= 1'b0;
      else if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR))
        r_par[waddr] <= ^wdata;
    end
  end

  assign w_sp1 = (raddr1 == ADDR_W'(NOP_REG_ADDR)) ? 1'b0 : r_par[raddr1];
  assign w_sp2 = (raddr2 == ADDR_W'(NOP_REG_ADDR)) ? 1'b0 : r_par[raddr2];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)
      r_par_err <= 1'b0;
    else if (w_bad1 || w_bad2)
      r_par_err <= 1'b1;
  end

  assign par_err_o = r_par_err;
`else
  assign par_err_o = 1'b0;
`endif

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .i_rst        (rst),
    .i_run        (w_run),
    .i_re         (re1),
    .i_raddr      (raddr1),
    .i_we         (we),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_store_data (w_st1),
`ifdef REGFILE_PARITY_EN
    .i_store_par  (w_sp1),
    .o_par_bad    (w_bad1),
`endif
    .o_rdata      (rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .i_rst        (rst),
    .i_run        (w_run),
    .i_re         (re2),
    .i_raddr      (raddr2),
    .i_we         (we),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_store_data (w_st2),
`ifdef REGFILE_PARITY_EN
    .i_store_par  (w_sp2),
    .o_par_bad    (w_bad2),
`endif
    .o_rdata      (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: driver pushes expected outputs from a behavioural model,
// a negedge monitor pops and compares. Parity checks run when REGFILE_PARITY_EN is defined.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        ready_o, par_err_o;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ready_o(ready_o), .par_err_o(par_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy;
    logic        perr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: architectural contents plus "sweep cycles elapsed since reset".
  logic [31:0] m_mem [32];
  bit          m_corrupt [32];
  bit          m_known = 0;
  bit          m_ready = 0;
  bit          m_perr = 0;
  int          m_cnt = 0;

  function automatic logic [31:0] exp_rd(input logic e, input logic [4:0] a);
    if (rst || !m_ready || a == 5'd0) return 32'h0;
    if (e && we && waddr == a) return wdata;
    if (e) return m_mem[a];
    return 32'h0;
  endfunction

  function automatic bit par_hit(input logic e, input logic [4:0] a);
    return !rst && m_ready && a != 5'd0 && e && !(we && waddr == a) && m_corrupt[a];
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit e1, input logic [4:0] a1, input bit e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    if (m_known) begin
      exp_t e;
      e.d1 = exp_rd(e1, a1);
      e.d2 = exp_rd(e2, a2);
      e.rdy = m_ready;
      e.perr = m_perr;
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_ready = 0; m_cnt = 0; m_perr = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 31) begin
        m_ready = 1;
        for (int i = 0; i < 32; i++) begin
          m_mem[i] = 32'h0;
          m_corrupt[i] = 0;
        end
      end
    end else begin
      if (par_hit(e1, a1) || par_hit(e2, a2)) m_perr = 1;
      if (w && wa != 5'd0) begin
        m_mem[wa] = wd;
        m_corrupt[wa] = 0;
      end
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] a);
    step(0, 0, 5'd0, 32'h0, 1, a, 1, a);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata1", rdata1, e.d1);
      chk("rdata2", rdata2, e.d2);
      chk("ready_o", {31'h0, ready_o}, {31'h0, e.rdy});
      chk("par_err_o", {31'h0, par_err_o}, {31'h0, e.perr});
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'h0;
      m_corrupt[i] = 0;
    end
    repeat (3) step(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);

    // Sweep: 30 posedges of not-ready, then reads of every register.
    for (int i = 1; i <= 30; i++)
      step(0, 1, 5'(i), 32'hFFFF_0000, 1, 5'(i), 1, 5'(31 - i));
    for (int i = 1; i <= 31; i++)
      idle_read(5'(i));

    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd5, 0, 5'd5);
    step(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5);
    step(0, 0, 5'd0, 32'h0, 0, 5'd5, 1, 5'd5);
    step(0, 1, 5'd7, 32'h1234_5678, 1, 5'd7, 1, 5'd7);
    idle_read(5'd7);
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
    idle_read(5'd0);

    step(0, 1, 5'd9, 32'hA5A5_A5A5, 1, 5'd9, 1, 5'd9);
    idle_read(5'd9);
    step(1, 1, 5'd9, 32'h0BAD_0BAD, 1, 5'd9, 1, 5'd9);
    step(0, 1, 5'd9, 32'h1111_1111, 1, 5'd9, 1, 5'd9);
    repeat (31) idle_read(5'd9);
    idle_read(5'd9);

`ifdef REGFILE_PARITY_EN
    step(0, 1, 5'd4, 32'h0F0F_0F0F, 1, 5'd4, 1, 5'd4);
    idle_read(5'd4);
    dut.r_regs[4] = dut.r_regs[4] ^ 32'h0000_0008;
    m_mem[4] = m_mem[4] ^ 32'h0000_0008;
    m_corrupt[4] = 1;
    step(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0);
    repeat (3) idle_read(5'd1);
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
    repeat (32) idle_read(5'd4);
`endif

    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, a1, a2;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 149) == 0), 1'($urandom), wa, $urandom,
           1'($urandom), a1, 1'($urandom), a2);
    end
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);

    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32x32 general-purpose register file: the responder for the ID stage's two register-read request ports, and the sink for the WB stage's write port.
- Reads are combinational, so ID sees operands in the same cycle it presents the address.
- Writes take effect at the clock edge, with write-to-read bypass.
- After reset, an internal sweep zeroes every register before normal operation starts.

Parameters:
- DATA_W, 32, register width; matches `RegBus.
- ADDR_W, 5, register address width; matches `RegAddrBus.
- NUM_REGS, 32, register count; 2**ADDR_W.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; synchronous, active-high (`RstEnable).
- we  in  1  write enable from WB.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read enable, port 1 (driven by ID reg1_read_o).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- ready_o  out  1  high when the clear sweep is done and the file accepts writes.
- par_err_o  out  1  sticky parity error; present only with the optional feature.

Behaviour:
- FSM states CLEAR and RUN; clear pointer clr_ptr[ADDR_W-1:0].
- While rst=1 at posedge: state<=CLEAR, clr_ptr<=1, ready_o<=0, par_err_o<=0. Register contents are not touched directly.
- CLEAR: each posedge, regs[clr_ptr]<=0 and clr_ptr++.
  - When clr_ptr==NUM_REGS-1, that register is cleared, state<=RUN and ready_o<=1.
  - ready_o rises at the 31st posedge after rst deasserts.
- RUN: at posedge, if we=1 and waddr!=0, regs[waddr]<=wdata.
- Writes with waddr=0 are dropped.
- Writes during CLEAR or while rst=1 are dropped. WB must respect ready_o; this block does not stall.
- rst asserted mid-sweep or mid-operation restarts the sweep from clr_ptr=1. No partial write completes in a reset cycle.
- Read, per port n, combinational, in priority order:
  1. rst=1 -> 0.
  2. state=CLEAR -> 0.
  3. raddrn=0 -> 0.
  4. ren=1 and we=1 and waddr==raddrn -> wdata (bypass).
  5. ren=1 -> regs[raddrn].
  6. ren=0 -> 0.
- Both ports may read the same address in the same cycle. Both receive identical data, including the bypass value.
- Register 0 is never stored. It reads 0 unconditionally.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit, written with data, including 0 during the sweep.
  - On a RUN-state read that takes data from storage (not a bypass read, not r0), parity is recomputed over the stored data.
  - A mismatch on either port sets par_err_o at the next posedge. It stays set until rst.
  - Read data is still returned unmodified.
- Undefined: no parity storage; par_err_o is tied 0.

Decomposition:
- Shared defines/package holds: `RegBus, `RegAddrBus, `RegNum, `RstEnable, `WriteEnable, `ReadEnable, `ZeroWord, `NOPRegAddr.
- Add the FSM state encodings RF_CLEAR and RF_RUN to that package.
- One natural sub-module: regfile_rd_port, instantiated twice, implementing the read-priority mux plus the parity check.

Test Plan:
- Hold rst 3 cycles, release -> ready_o=0 for 30 posedges, 1 at the 31st; reads of r1..r31 return 0x00000000.
- RUN: write r5=0xDEADBEEF, next cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF. With re1=0 -> rdata1=0.
- Same cycle: we=1, waddr=7, wdata=0x12345678, re1=re2=1, raddr1=raddr2=7 -> both ports 0x12345678 before the edge.
- Write r0=0xFFFFFFFF, then read r0 on both ports -> 0. Also with we=1, waddr=0 the same cycle -> still 0 (no bypass).
- Mid-operation: r9=0xA5A5A5A5, assert rst 1 cycle -> ready_o=0. A write to r9 during the sweep is dropped. After ready_o=1, r9 reads 0.
- REGFILE_PARITY_EN: force-flip bit 3 of stored r4, read r4 -> par_err_o=1 next cycle and stays 1 until rst. A bypass read of r4 during the write cycle raises no error.
